// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
//   fwd_sel_t   : EXE operand mux select (register file, WB latch, MEM latch)
//   hz_entry_t  : shadow copy of one in-flight writer {valid, regwrite, memtoreg, dst}
//   BRANCH_*    : stage numbers at which pcsrc may resolve
//   writes_reg(): "this entry will write register r" test shared by all comparators
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Shadow entries carry the destination zero-extended to this width so one
  // struct type serves every REG_W up to REG_W_MAX.
  localparam int REG_W_MAX = 8;

  localparam int BRANCH_EXE = 2;
  localparam int BRANCH_MEM = 3;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 memtoreg;
    logic [REG_W_MAX-1:0] dst;
  } hz_entry_t;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic writes_reg(hz_entry_t e, logic [REG_W_MAX-1:0] r);
    return e.valid && e.regwrite && (e.dst != '0) && (e.dst == r);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Bundle between the pipeline datapath and the hazard unit.
//   master : datapath side, drives the DEC-stage description and pcsrc,
//            receives stall/bubble/flush/forwarding and the perf counters
//   slave  : hazard unit side
interface pipe_hazard_if #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                     valid_DEC;
  logic [NUM_SRC*REG_W-1:0] src_DEC;
  logic [NUM_SRC-1:0]       srcuse_DEC;
  logic [REG_W-1:0]         dst_DEC;
  logic                     regwrite_DEC;
  logic                     memtoreg_DEC;
  logic                     pcsrc;
  logic                     stall;
  logic                     bubble_EXE;
  logic                     flush_IFDEC;
  logic [NUM_SRC*2-1:0]     fwd_sel_EXE;
  logic [CNT_W-1:0]         stall_cnt;
  logic [CNT_W-1:0]         flush_cnt;

  modport master (
    output valid_DEC, src_DEC, srcuse_DEC, dst_DEC, regwrite_DEC, memtoreg_DEC, pcsrc,
    input  stall, bubble_EXE, flush_IFDEC, fwd_sel_EXE, stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_DEC, src_DEC, srcuse_DEC, dst_DEC, regwrite_DEC, memtoreg_DEC, pcsrc,
    output stall, bubble_EXE, flush_IFDEC, fwd_sel_EXE, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit_src_match.sv
// Per-operand comparator slice.
//   dec_src/dec_use : operand as seen in DEC, compared against EXE/MEM/WB
//   exe_src/exe_use : same operand slot of the instruction now in EXE,
//                     compared against MEM/WB to pick the forwarding source
//   exe/mem/wb      : shadow writer entries
//   dec_match       : {wb, mem, exe} hit vector for the DEC operand
//   fwd_sel         : forwarding select for the EXE operand (youngest wins)
module hazard_src_match
  import pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] dec_src,
  input  logic             dec_use,
  input  logic [REG_W-1:0] exe_src,
  input  logic             exe_use,
  input  hz_entry_t        exe,
  input  hz_entry_t        mem,
  input  hz_entry_t        wb,
  output logic [2:0]       dec_match,
  output fwd_sel_t         fwd_sel
);

  logic [REG_W_MAX-1:0] dec_ext;
  logic [REG_W_MAX-1:0] exe_ext;

  assign dec_ext = REG_W_MAX'(dec_src);
  assign exe_ext = REG_W_MAX'(exe_src);

  always_comb begin
    dec_match[0] = dec_use & writes_reg(exe, dec_ext);
    dec_match[1] = dec_use & writes_reg(mem, dec_ext);
    dec_match[2] = dec_use & writes_reg(wb,  dec_ext);

    // MEM is checked first: it holds the more recent write of the register.
    fwd_sel = FWD_REG;
    if (exe_use && writes_reg(mem, exe_ext)) begin
      fwd_sel = FWD_MEM;
    end else if (exe_use && writes_reg(wb, exe_ext)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Tracks the writers in EXE/MEM/WB in a shadow scoreboard and derives, purely
// combinationally from that state and the DEC description:
//   stall        : hold PC and IF/DEC latch
//   bubble_EXE   : load an empty instruction into DEC/EXE this edge
//   flush_IFDEC  : squash IF/DEC this edge (taken branch)
//   fwd_sel_EXE  : per-operand fwd_sel_t for the EXE operand muxes
//   stall_cnt / flush_cnt : saturating event counters
// Ports: clk, reset (asynchronous, active-low), hz (pipe_hazard_if.slave).
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int NUM_SRC      = 2,
  parameter int FWD_EN       = 1,
  parameter int BRANCH_STAGE = BRANCH_MEM,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  pipe_hazard_if.slave hz
);

  hz_entry_t                exe_reg, exe_next;
  hz_entry_t                mem_reg, mem_next;
  hz_entry_t                wb_reg;
  logic [NUM_SRC*REG_W-1:0] exe_src_reg, exe_src_next;
  logic [NUM_SRC-1:0]       exe_srcuse_reg, exe_srcuse_next;
  logic [CNT_W-1:0]         stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0]         flush_cnt_reg, flush_cnt_next;

  logic [NUM_SRC-1:0]       exe_hit, mem_hit, wb_hit;
  logic [NUM_SRC*2-1:0]     fwd_sel_vec;
  logic                     branch_taken;
  logic                     load_use;
  logic                     raw_any;
  logic                     hazard;
  logic                     stall;
  logic                     bubble;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [2:0] dec_match;
      fwd_sel_t   sel;

      hazard_src_match #(.REG_W(REG_W)) u_match (
        .dec_src   (hz.src_DEC[gi*REG_W +: REG_W]),
        .dec_use   (hz.srcuse_DEC[gi]),
        .exe_src   (exe_src_reg[gi*REG_W +: REG_W]),
        .exe_use   (exe_srcuse_reg[gi] & exe_reg.valid),
        .exe       (exe_reg),
        .mem       (mem_reg),
        .wb        (wb_reg),
        .dec_match (dec_match),
        .fwd_sel   (sel)
      );

      assign exe_hit[gi] = dec_match[0];
      assign mem_hit[gi] = dec_match[1];
      assign wb_hit[gi]  = dec_match[2];
      // Without forwarding every RAW is resolved by stalling, so the muxes
      // always take the register file.
      assign fwd_sel_vec[gi*2 +: 2] = (FWD_EN != 0) ? sel : FWD_REG;
    end
  endgenerate

  // pcsrc is a live input, so it is gated here to keep flush/bubble quiet
  // while reset is held; everything else is already zero via cleared state.
  assign branch_taken = hz.pcsrc & reset;
  assign load_use     = hz.valid_DEC & exe_reg.memtoreg & (|exe_hit);
  assign raw_any      = hz.valid_DEC & (|(exe_hit | mem_hit | wb_hit));
  assign hazard       = (FWD_EN != 0) ? load_use : raw_any;
  // A taken branch squashes DEC, so its hazard is moot and must not stall.
  assign stall        = hazard & ~branch_taken;
  assign bubble       = hazard | branch_taken;

  assign hz.stall       = stall;
  assign hz.bubble_EXE  = bubble;
  assign hz.flush_IFDEC = branch_taken;
  assign hz.fwd_sel_EXE = fwd_sel_vec;
  assign hz.stall_cnt   = stall_cnt_reg;
  assign hz.flush_cnt   = flush_cnt_reg;

  always_comb begin
    exe_next.valid    = hz.valid_DEC;
    exe_next.regwrite = hz.regwrite_DEC;
    exe_next.memtoreg = hz.memtoreg_DEC;
    exe_next.dst      = REG_W_MAX'(hz.dst_DEC);
    exe_src_next      = hz.src_DEC;
    exe_srcuse_next   = hz.srcuse_DEC;
    if (bubble) begin
      exe_next        = '0;
      exe_src_next    = '0;
      exe_srcuse_next = '0;
    end

    // Branch resolving in MEM: the instruction behind it (now in EXE) is on
    // the wrong path and must not reach MEM.
    mem_next = exe_reg;
    if (branch_taken && (BRANCH_STAGE == BRANCH_MEM)) begin
      mem_next = '0;
    end

    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end

    flush_cnt_next = flush_cnt_reg;
    if (branch_taken && (flush_cnt_reg != '1)) begin
      flush_cnt_next = flush_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exe_reg        <= '0;
      mem_reg        <= '0;
      wb_reg         <= '0;
      exe_src_reg    <= '0;
      exe_srcuse_reg <= '0;
      stall_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      exe_reg        <= exe_next;
      mem_reg        <= mem_next;
      wb_reg         <= mem_reg;
      exe_src_reg    <= exe_src_next;
      exe_srcuse_reg <= exe_srcuse_next;
      stall_cnt_reg  <= stall_cnt_next;
      flush_cnt_reg  <= flush_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench: the driver applies one DEC description per cycle and
// queues the hand-computed response; a monitor on the falling edge pops and
// compares. u_fwd: forwarding, branch in MEM. u_nofwd: stall-only, 4-bit
// counters so saturation is reachable in a few cycles.
module tb_pipe_hazard_unit;

  typedef struct {
    int          dut;
    logic        st;
    logic        bu;
    logic        fl;
    logic [3:0]  fwd;
    logic [15:0] sc;
    logic [15:0] fc;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb_q[$];
  int   checks;
  int   errors;

  pipe_hazard_if #(.REG_W(5), .NUM_SRC(2), .CNT_W(16)) if_a ();
  pipe_hazard_if #(.REG_W(5), .NUM_SRC(2), .CNT_W(4))  if_b ();

  pipe_hazard_unit #(.REG_W(5), .NUM_SRC(2), .FWD_EN(1), .BRANCH_STAGE(3), .CNT_W(16)) u_fwd (
    .clk   (clk),
    .reset (reset),
    .hz    (if_a.slave)
  );

  pipe_hazard_unit #(.REG_W(5), .NUM_SRC(2), .FWD_EN(0), .BRANCH_STAGE(3), .CNT_W(4)) u_nofwd (
    .clk   (clk),
    .reset (reset),
    .hz    (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // args: dut, reset level, assert reset mid-cycle, DEC {valid, rs, rt, srcuse,
  // dst, regwrite, memtoreg}, pcsrc, expected {stall, bubble, flush, fwd, stall_cnt, flush_cnt}
  task automatic step(input int dut, input logic rst_v, input logic mid_rst,
                      input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] su, input logic [4:0] dst, input logic rw,
                      input logic mtr, input logic pc,
                      input logic st, input logic bu, input logic fl,
                      input logic [3:0] fwd, input logic [15:0] sc, input logic [15:0] fc,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v;
    if (dut == 0) begin
      if_a.valid_DEC = v;  if_a.src_DEC = {rt, rs}; if_a.srcuse_DEC = su;
      if_a.dst_DEC = dst;  if_a.regwrite_DEC = rw;  if_a.memtoreg_DEC = mtr;
      if_a.pcsrc = pc;
      if_b.valid_DEC = 1'b0; if_b.srcuse_DEC = 2'b00; if_b.pcsrc = 1'b0;
    end else begin
      if_b.valid_DEC = v;  if_b.src_DEC = {rt, rs}; if_b.srcuse_DEC = su;
      if_b.dst_DEC = dst;  if_b.regwrite_DEC = rw;  if_b.memtoreg_DEC = mtr;
      if_b.pcsrc = pc;
      if_a.valid_DEC = 1'b0; if_a.srcuse_DEC = 2'b00; if_a.pcsrc = 1'b0;
    end
    e.dut = dut; e.st = st; e.bu = bu; e.fl = fl; e.fwd = fwd;
    e.sc = sc; e.fc = fc; e.name = name;
    sb_q.push_back(e);
    if (mid_rst) begin
      #2;
      reset = 1'b0;
    end
  endtask

  // Monitor
  exp_t        m_e;
  logic        g_st, g_bu, g_fl;
  logic [3:0]  g_fwd;
  logic [15:0] g_sc, g_fc;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      if (m_e.dut == 0) begin
        g_st = if_a.stall; g_bu = if_a.bubble_EXE; g_fl = if_a.flush_IFDEC;
        g_fwd = if_a.fwd_sel_EXE; g_sc = if_a.stall_cnt; g_fc = if_a.flush_cnt;
      end else begin
        g_st = if_b.stall; g_bu = if_b.bubble_EXE; g_fl = if_b.flush_IFDEC;
        g_fwd = if_b.fwd_sel_EXE; g_sc = {12'd0, if_b.stall_cnt}; g_fc = {12'd0, if_b.flush_cnt};
      end
      checks++;
      if ({g_st, g_bu, g_fl, g_fwd, g_sc, g_fc} !==
          {m_e.st, m_e.bu, m_e.fl, m_e.fwd, m_e.sc, m_e.fc}) begin
        errors++;
        $display("FAIL %s: got stall=%b bubble=%b flush=%b fwd=%b scnt=%0h fcnt=%0h, want stall=%b bubble=%b flush=%b fwd=%b scnt=%0h fcnt=%0h",
                 m_e.name, g_st, g_bu, g_fl, g_fwd, g_sc, g_fc,
                 m_e.st, m_e.bu, m_e.fl, m_e.fwd, m_e.sc, m_e.fc);
      end else begin
        $display("pass %s: stall=%b bubble=%b flush=%b fwd=%b scnt=%0h fcnt=%0h",
                 m_e.name, g_st, g_bu, g_fl, g_fwd, g_sc, g_fc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, want completion before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sc;
    logic st;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    if_a.valid_DEC = 1'b0; if_a.src_DEC = '0; if_a.srcuse_DEC = '0; if_a.dst_DEC = '0;
    if_a.regwrite_DEC = 1'b0; if_a.memtoreg_DEC = 1'b0; if_a.pcsrc = 1'b0;
    if_b.valid_DEC = 1'b0; if_b.src_DEC = '0; if_b.srcuse_DEC = '0; if_b.dst_DEC = '0;
    if_b.regwrite_DEC = 1'b0; if_b.memtoreg_DEC = 1'b0; if_b.pcsrc = 1'b0;

    // Reset held with live DEC inputs and pcsrc=1: all outputs quiet.
    step(0,0,0, 1,5'd3,5'd3,2'b11,5'd4,1,0,1, 0,0,0,4'b0000,0,0, "rst_hold_a");
    step(0,0,0, 1,5'd3,5'd3,2'b11,5'd4,1,0,1, 0,0,0,4'b0000,0,0, "rst_hold_b");
    // add $3,$1,$2 ; sub $4,$3,$5 -> MEM forward on op0
    step(0,1,0, 1,5'd1,5'd2,2'b11,5'd3,1,0,0, 0,0,0,4'b0000,0,0, "t1_add_dec");
    step(0,1,0, 1,5'd3,5'd5,2'b11,5'd4,1,0,0, 0,0,0,4'b0000,0,0, "t1_sub_dec");
    step(0,1,0, 0,5'd0,5'd0,2'b00,5'd0,0,0,0, 0,0,0,4'b0010,0,0, "t1_sub_exe_fwdmem");
    // or $6,$3,$4 one slot behind sub -> WB forward on op1
    step(0,1,0, 1,5'd3,5'd4,2'b11,5'd6,1,0,0, 0,0,0,4'b0000,0,0, "wb_or_dec");
    step(0,1,0, 0,5'd0,5'd0,2'b00,5'd0,0,0,0, 0,0,0,4'b0100,0,0, "wb_or_exe_fwdwb");
    // Two writers of $3 back to back: MEM (youngest) wins on both operands
    step(0,1,0, 1,5'd1,5'd0,2'b01,5'd3,1,0,0, 0,0,0,4'b0000,0,0, "yw_a");
    step(0,1,0, 1,5'd2,5'd0,2'b01,5'd3,1,0,0, 0,0,0,4'b0000,0,0, "yw_b");
    step(0,1,0, 1,5'd3,5'd3,2'b11,5'd7,1,0,0, 0,0,0,4'b0000,0,0, "yw_reader_dec");
    step(0,1,0, 0,5'd0,5'd0,2'b00,5'd0,0,0,0, 0,0,0,4'b1010,0,0, "yw_exe_mem_wins");
    // Load to $0 then reader of $0: no stall, register file
    step(0,1,0, 1,5'd1,5'd0,2'b01,5'd0,1,1,0, 0,0,0,4'b0000,0,0, "r0_load_dec");
    step(0,1,0, 1,5'd0,5'd0,2'b11,5'd8,1,0,0, 0,0,0,4'b0000,0,0, "r0_reader_nostall");
    step(0,1,0, 0,5'd0,5'd0,2'b00,5'd0,0,0,0, 0,0,0,4'b0000,0,0, "r0_reader_fwdreg");
    // lw $3,0($0) ; add $4,$3,$3 -> one stall cycle, then WB forward both
    step(0,1,0, 1,5'd0,5'd0,2'b01,5'd3,1,1,0, 0,0,0,4'b0000,0,0, "lu_load");
    step(0,1,0, 1,5'd3,5'd3,2'b11,5'd4,1,0,0, 1,1,0,4'b0000,0,0, "lu_stall");
    step(0,1,0, 1,5'd3,5'd3,2'b11,5'd4,1,0,0, 0,0,0,4'b0000,1,0, "lu_release");
    step(0,1,0, 0,5'd0,5'd0,2'b00,5'd0,0,0,0, 0,0,0,4'b0101,1,0, "lu_exe_fwdwb");
    // Taken branch over a load-use hazard: flush wins, EXE load dropped
    step(0,1,0, 1,5'd0,5'd0,2'b01,5'd5,1,1,0, 0,0,0,4'b0000,1,0, "br_load");
    step(0,1,0, 1,5'd5,5'd5,2'b11,5'd6,1,0,1, 0,1,1,4'b0000,1,0, "br_flush_over_stall");
    step(0,1,0, 1,5'd5,5'd0,2'b01,5'd9,1,0,0, 0,0,0,4'b0000,1,1, "br_reader_dec");
    step(0,1,0, 0,5'd0,5'd0,2'b00,5'd0,0,0,0, 0,0,0,4'b0000,1,1, "br_exe_load_dropped");
    // Reset asserted in the middle of a stall cycle
    step(0,1,0, 1,5'd0,5'd0,2'b01,5'd3,1,1,0, 0,0,0,4'b0000,1,1, "rst_pre_load");
    step(0,1,1, 1,5'd3,5'd3,2'b11,5'd4,1,0,1, 0,0,0,4'b0000,0,0, "rst_mid_stall");
    step(0,0,0, 1,5'd3,5'd3,2'b11,5'd4,1,0,1, 0,0,0,4'b0000,0,0, "rst_hold_c");
    step(0,1,0, 0,5'd0,5'd0,2'b00,5'd0,0,0,0, 0,0,0,4'b0000,0,0, "rst_release");
    step(0,1,0, 1,5'd0,5'd0,2'b01,5'd3,1,1,0, 0,0,0,4'b0000,0,0, "post_rst_load");
    step(0,1,0, 1,5'd3,5'd3,2'b11,5'd4,1,0,0, 1,1,0,4'b0000,0,0, "post_rst_stall");
    step(0,1,0, 0,5'd0,5'd0,2'b00,5'd0,0,0,0, 0,0,0,4'b0000,1,0, "post_rst_cnt");

    // No forwarding: add $3,$1,$2 ; or $6,$3,$0 -> 3 stall cycles
    step(1,1,0, 1,5'd1,5'd2,2'b11,5'd3,1,0,0, 0,0,0,4'b0000,0,0, "nf_add");
    step(1,1,0, 1,5'd3,5'd0,2'b11,5'd6,1,0,0, 1,1,0,4'b0000,0,0, "nf_stall_exe");
    step(1,1,0, 1,5'd3,5'd0,2'b11,5'd6,1,0,0, 1,1,0,4'b0000,1,0, "nf_stall_mem");
    step(1,1,0, 1,5'd3,5'd0,2'b11,5'd6,1,0,0, 1,1,0,4'b0000,2,0, "nf_stall_wb");
    step(1,1,0, 1,5'd3,5'd0,2'b11,5'd6,1,0,0, 0,0,0,4'b0000,3,0, "nf_release");
    // add $3,$3,$3 held in DEC: stalls 3 of every 4 cycles until 4-bit counter saturates
    exp_sc = 3;
    for (int k = 0; k < 24; k++) begin
      st = ((k % 4) != 0);
      step(1,1,0, 1,5'd3,5'd3,2'b11,5'd3,1,0,0, st,st,0,4'b0000,16'(exp_sc),0,
           $sformatf("nf_sat_%0d", k));
      if (st && exp_sc < 15) exp_sc++;
    end
    step(1,1,0, 0,5'd0,5'd0,2'b00,5'd0,0,0,0, 0,0,0,4'b0000,16'hF,0, "nf_sat_final");

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
